// File: rtl/clock_gating_ctrl_multi.sv
// rtl/clock_gating_ctrl_multi.sv - multi-channel idle-hysteresis clock gating controller
module clock_gating_ctrl_multi #(
    parameter int NUM_CH      = 4,
    parameter int IDLE_CYCLES = 8,
    parameter int WAKE_CYCLES = 2,
    localparam int MAX_CNT    = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES,
    localparam int CNT_W      = $clog2(MAX_CNT + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              scan_cg_en_i,
    input  logic [NUM_CH-1:0] busy_i,
    input  logic [NUM_CH-1:0] force_on_i,
    output logic [NUM_CH-1:0] clk_o,
    output logic [NUM_CH-1:0] ready_o,
    output logic [NUM_CH-1:0] gated_o
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_IDLE = 2'd1,
        ST_OFF  = 2'd2,
        ST_WAKE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_t           state;
        state_t           state_nxt;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nxt;
        logic             act;
        logic             en;
        logic             ready_nxt;
        logic             gated_nxt;
        logic             ready_q;
        logic             gated_q;
        logic             latch_q;

        assign act = busy_i[c] | force_on_i[c];

        // State, counter and registered status flags; reset returns the channel to RUN
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state   <= ST_RUN;
                cnt     <= '0;
                ready_q <= 1'b1;
                gated_q <= 1'b0;
            end else begin
                state   <= state_nxt;
                cnt     <= cnt_nxt;
                ready_q <= ready_nxt;
                gated_q <= gated_nxt;
            end
        end

        // Next state: idle hysteresis into OFF, fixed wake-up delay back to RUN
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            case (state)
                ST_RUN: begin
                    if (!act) begin
                        if (IDLE_CYCLES == 1) begin
                            state_nxt = ST_OFF;
                        end else begin
                            state_nxt = ST_IDLE;
                            cnt_nxt   = CNT_ONE;
                        end
                    end
                end
                ST_IDLE: begin
                    if (act) begin
                        state_nxt = ST_RUN;
                        cnt_nxt   = '0;
                    end else if (cnt == IDLE_LAST) begin
                        state_nxt = ST_OFF;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                ST_OFF: begin
                    if (act) begin
                        if (WAKE_CYCLES == 0) begin
                            state_nxt = ST_RUN;
                        end else begin
                            state_nxt = ST_WAKE;
                            cnt_nxt   = CNT_ONE;
                        end
                    end
                end
                ST_WAKE: begin
                    // activity is deliberately ignored until the clock is stable again
                    if (cnt == WAKE_LAST) begin
                        state_nxt = ST_RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end
            endcase
        end

        // Outputs: cell enable from current state, status flags pre-decoded from next state
        always_comb begin
            en        = (state != ST_OFF);
            ready_nxt = (state_nxt == ST_RUN) || (state_nxt == ST_IDLE);
            gated_nxt = (state_nxt == ST_OFF);
        end

        // Gating latch: transparent in the low phase so enable changes never chop a high pulse
        always_latch begin
            if (!clk_i) begin
                latch_q <= en | scan_cg_en_i | ~rst_ni;
            end
        end

        assign clk_o[c]   = clk_i & latch_q;
        assign ready_o[c] = ready_q;
        assign gated_o[c] = gated_q;
    end

endmodule

// File: tb/tb_clock_gating_ctrl_multi.sv
// tb/tb_clock_gating_ctrl_multi.sv - randomized model-checked bench for clock_gating_ctrl_multi
module tb_clock_gating_ctrl_multi;

    localparam int NCH = 4;

    logic           clk = 1'b0;
    logic           rst_ni = 1'b0;
    logic           scan = 1'b0;
    logic [NCH-1:0] busy = '1;
    logic [NCH-1:0] force_on = '0;
    logic [NCH-1:0] clk_a, rdy_a, gat_a;
    logic [NCH-1:0] clk_b, rdy_b, gat_b;

    int total = 0;
    int bad = 0;

    // Model state per DUT (0 = default params, 1 = IDLE_CYCLES=1/WAKE_CYCLES=0)
    int idle_p[2] = '{8, 1};
    int wake_p[2] = '{2, 0};
    bit m_off[2][NCH];
    int m_idle[2][NCH];
    int m_wake[2][NCH];
    int wake_resets = 0;

    clock_gating_ctrl_multi #(.NUM_CH(NCH)) dut_a (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .scan_cg_en_i(scan),
        .busy_i      (busy),
        .force_on_i  (force_on),
        .clk_o       (clk_a),
        .ready_o     (rdy_a),
        .gated_o     (gat_a)
    );

    clock_gating_ctrl_multi #(.NUM_CH(NCH), .IDLE_CYCLES(1), .WAKE_CYCLES(0)) dut_b (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .scan_cg_en_i(scan),
        .busy_i      (busy),
        .force_on_i  (force_on),
        .clk_o       (clk_b),
        .ready_o     (rdy_b),
        .gated_o     (gat_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NCH; c++) begin
                m_off[d][c]  = 1'b0;
                m_idle[d][c] = 0;
                m_wake[d][c] = 0;
            end
        end
    endfunction

    // One sampled clock edge of one channel: count idle run, countdown wake delay
    function automatic void model_edge(input int d, input int c, input bit act);
        if (m_off[d][c]) begin
            if (act) begin
                m_off[d][c]  = 1'b0;
                m_wake[d][c] = wake_p[d];
            end
        end else if (m_wake[d][c] > 0) begin
            m_wake[d][c]--;
        end else if (act) begin
            m_idle[d][c] = 0;
        end else begin
            m_idle[d][c]++;
            if (m_idle[d][c] == idle_p[d]) begin
                m_off[d][c]  = 1'b1;
                m_idle[d][c] = 0;
            end
        end
    endfunction

    function automatic logic [NCH-1:0] exp_ready(input int d);
        logic [NCH-1:0] r;
        for (int c = 0; c < NCH; c++) r[c] = !m_off[d][c] && (m_wake[d][c] == 0);
        return r;
    endfunction

    function automatic logic [NCH-1:0] exp_gated(input int d);
        logic [NCH-1:0] g;
        for (int c = 0; c < NCH; c++) g[c] = m_off[d][c];
        return g;
    endfunction

    // Advance one edge, check gated clocks in the high phase, then status after the edge
    task automatic step();
        logic [NCH-1:0] en_pre[2];
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NCH; c++) en_pre[d][c] = !m_off[d][c] || scan || !rst_ni;
        end
        check("clk_a", 32'(clk_a), 32'(en_pre[0]));
        check("clk_b", 32'(clk_b), 32'(en_pre[1]));
        if (rst_ni) begin
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < NCH; c++) model_edge(d, c, busy[c] | force_on[c]);
            end
        end else begin
            model_reset();
        end
        check("ready_a", 32'(rdy_a), 32'(exp_ready(0)));
        check("gated_a", 32'(gat_a), 32'(exp_gated(0)));
        check("ready_b", 32'(rdy_b), 32'(exp_ready(1)));
        check("gated_b", 32'(gat_b), 32'(exp_gated(1)));
        #1;
    endtask

    // Asynchronous reset pulse between edges, released during the low phase
    task automatic reset_pulse();
        #1;
        rst_ni = 1'b0;
        #1;
        check("rst_ready_a", 32'(rdy_a), 32'hF);
        check("rst_gated_a", 32'(gat_a), 32'h0);
        check("rst_ready_b", 32'(rdy_b), 32'hF);
        check("rst_gated_b", 32'(gat_b), 32'h0);
        model_reset();
        #3;
        rst_ni = 1'b1;
    endtask

    initial begin
        int pr[NCH];
        model_reset();
        for (int i = 0; i < 3; i++) step();
        rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) step();

        for (int blk = 0; blk < 40; blk++) begin
            for (int c = 0; c < NCH; c++) begin
                case ($urandom_range(0, 3))
                    0: pr[c] = 0;
                    1: pr[c] = 3;
                    2: pr[c] = 30;
                    default: pr[c] = 90;
                endcase
            end
            scan = ($urandom_range(0, 3) == 0);
            for (int cyc = 0; cyc < 64; cyc++) begin
                for (int c = 0; c < NCH; c++) begin
                    busy[c]     = ($urandom_range(0, 99) < pr[c]);
                    force_on[c] = ($urandom_range(0, 49) == 0);
                end
                step();
                if (m_wake[0][0] > 0 && wake_resets < 6 && $urandom_range(0, 3) == 0) begin
                    wake_resets++;
                    reset_pulse();
                end else if ($urandom_range(0, 499) == 0) begin
                    reset_pulse();
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
